// File: rtl/bp_axil_master_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite master port among several requesters.
// Responses are routed back in order through one ID FIFO per channel (R and B).

module bp_axil_id_fifo #(
    parameter int depth_p = 8,
    parameter int width_p = 1
) (
    input  logic               m_axil_aclk,
    input  logic               reset,
    input  logic               push,
    input  logic [width_p-1:0] push_id,
    input  logic               pop,
    output logic [width_p-1:0] head_id,
    output logic               empty
);
    localparam int ptr_w = (depth_p > 1) ? $clog2(depth_p) : 1;
    localparam int cnt_w = $clog2(depth_p + 1);
    localparam logic [ptr_w-1:0] last_ptr = ptr_w'(depth_p - 1);

    logic [width_p-1:0] mem_r [depth_p];
    logic [ptr_w-1:0]   wr_ptr_r;
    logic [ptr_w-1:0]   rd_ptr_r;
    logic [cnt_w-1:0]   used_r;

    always_ff @(posedge m_axil_aclk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            used_r   <= '0;
        end else begin
            if (push) begin
                wr_ptr_r <= (wr_ptr_r == last_ptr) ? '0 : wr_ptr_r + ptr_w'(1);
            end
            if (pop) begin
                rd_ptr_r <= (rd_ptr_r == last_ptr) ? '0 : rd_ptr_r + ptr_w'(1);
            end
            if (push && !pop) begin
                used_r <= used_r + cnt_w'(1);
            end else if (pop && !push) begin
                used_r <= used_r - cnt_w'(1);
            end
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge m_axil_aclk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= push_id;
        end
    end

    assign head_id = mem_r[rd_ptr_r];
    assign empty   = (used_r == '0);
endmodule

module bp_axil_master_arbiter #(
    parameter int num_req_p         = 2,
    parameter int addr_width_p      = 64,
    parameter int data_width_p      = 32,
    parameter int max_outstanding_p = 8
) (
    input  logic                              m_axil_aclk,
    input  logic                              reset,

    input  logic [num_req_p-1:0]              req_v_i,
    input  logic [num_req_p-1:0]              req_w_i,
    input  logic [num_req_p*addr_width_p-1:0] req_addr_i,
    input  logic [num_req_p*data_width_p-1:0] req_data_i,
    output logic [num_req_p-1:0]              req_ready_and_o,

    output logic [num_req_p-1:0]              resp_v_o,
    output logic                              resp_w_o,
    output logic [data_width_p-1:0]           resp_data_o,
    output logic                              resp_err_o,
    input  logic [num_req_p-1:0]              resp_ready_and_i,

    output logic [addr_width_p-1:0]           m_axil_awaddr,
    output logic                              m_axil_awvalid,
    input  logic                              m_axil_awready,
    output logic [2:0]                        m_axil_awprot,
    output logic [data_width_p-1:0]           m_axil_wdata,
    output logic [data_width_p/8-1:0]         m_axil_wstrb,
    output logic                              m_axil_wvalid,
    input  logic                              m_axil_wready,
    input  logic                              m_axil_bvalid,
    output logic                              m_axil_bready,
    input  logic [1:0]                        m_axil_bresp,
    output logic [addr_width_p-1:0]           m_axil_araddr,
    output logic                              m_axil_arvalid,
    input  logic                              m_axil_arready,
    output logic [2:0]                        m_axil_arprot,
    input  logic [data_width_p-1:0]           m_axil_rdata,
    input  logic                              m_axil_rvalid,
    output logic                              m_axil_rready,
    input  logic [1:0]                        m_axil_rresp,

    output logic                              proto_err_o
);
    localparam int idx_w = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int cnt_w = $clog2(max_outstanding_p + 1);
    localparam logic [cnt_w-1:0] max_cnt = cnt_w'(max_outstanding_p);

    // e_idle: arbitrate | e_read: AR in flight | e_write: AW and/or W in flight
    typedef enum logic [1:0] {e_idle, e_read, e_write} state_e;

    state_e           state_r, state_n;
    logic [idx_w-1:0] grant_r, grant_n;
    logic [idx_w-1:0] rr_ptr_r, rr_ptr_n;
    logic [idx_w-1:0] pick;
    logic             pick_v;
    logic [cnt_w-1:0] count_r, count_n;
    logic             aw_done_r, aw_done_n;
    logic             w_done_r, w_done_n;
    logic             proto_err_r;
    logic             issue_rd, issue_wr;
    logic             r_pop, b_pop, r_sink, b_sink, r_owns_bus;
    logic [idx_w-1:0] r_head, b_head;
    logic             rd_empty, wr_empty;

    function automatic logic [idx_w-1:0] wrap_add(input logic [idx_w-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= num_req_p) s = s - num_req_p;
        return idx_w'(s);
    endfunction

    // Walk downwards so the nearest valid index at or after rr_ptr wins.
    always_comb begin
        pick   = '0;
        pick_v = 1'b0;
        for (int k = num_req_p - 1; k >= 0; k--) begin
            if (req_v_i[wrap_add(rr_ptr_r, k)]) begin
                pick   = wrap_add(rr_ptr_r, k);
                pick_v = 1'b1;
            end
        end
    end

    always_comb begin
        state_n         = state_r;
        grant_n         = grant_r;
        rr_ptr_n        = rr_ptr_r;
        aw_done_n       = aw_done_r;
        w_done_n        = w_done_r;
        m_axil_arvalid  = 1'b0;
        m_axil_awvalid  = 1'b0;
        m_axil_wvalid   = 1'b0;
        issue_rd        = 1'b0;
        issue_wr        = 1'b0;
        req_ready_and_o = '0;
        unique case (state_r)
            e_idle: begin
                if (pick_v && (count_r < max_cnt)) begin
                    grant_n = pick;
                    state_n = req_w_i[pick] ? e_write : e_read;
                end
            end
            e_read: begin
                m_axil_arvalid = 1'b1;
                if (m_axil_arready) begin
                    issue_rd                 = 1'b1;
                    req_ready_and_o[grant_r] = 1'b1;
                    rr_ptr_n                 = wrap_add(grant_r, 1);
                    state_n                  = e_idle;
                end
            end
            e_write: begin
                m_axil_awvalid = ~aw_done_r;
                m_axil_wvalid  = ~w_done_r;
                if ((aw_done_r || m_axil_awready) && (w_done_r || m_axil_wready)) begin
                    issue_wr                 = 1'b1;
                    req_ready_and_o[grant_r] = 1'b1;
                    aw_done_n                = 1'b0;
                    w_done_n                 = 1'b0;
                    rr_ptr_n                 = wrap_add(grant_r, 1);
                    state_n                  = e_idle;
                end else begin
                    aw_done_n = aw_done_r | m_axil_awready;
                    w_done_n  = w_done_r | m_axil_wready;
                end
            end
            default: state_n = e_idle;
        endcase
    end

    assign m_axil_araddr = req_addr_i[int'(grant_r)*addr_width_p +: addr_width_p];
    assign m_axil_awaddr = req_addr_i[int'(grant_r)*addr_width_p +: addr_width_p];
    assign m_axil_wdata  = req_data_i[int'(grant_r)*data_width_p +: data_width_p];
    assign m_axil_awprot = '0;
    assign m_axil_arprot = '0;
    assign m_axil_wstrb  = '1;

    // The response bus is shared, so only one beat is delivered per cycle and R has priority.
    always_comb begin
        resp_v_o      = '0;
        resp_w_o      = 1'b0;
        resp_data_o   = '0;
        resp_err_o    = 1'b0;
        m_axil_rready = 1'b0;
        m_axil_bready = 1'b0;
        r_pop         = 1'b0;
        b_pop         = 1'b0;
        r_sink        = 1'b0;
        b_sink        = 1'b0;
        r_owns_bus    = 1'b0;
        if (reset) begin
            if (m_axil_rvalid) begin
                if (rd_empty) begin
                    r_sink        = 1'b1;
                    m_axil_rready = 1'b1;
                end else begin
                    r_owns_bus       = 1'b1;
                    resp_v_o[r_head] = 1'b1;
                    resp_data_o      = m_axil_rdata;
                    resp_err_o       = (m_axil_rresp != 2'b00);
                    m_axil_rready    = resp_ready_and_i[r_head];
                    r_pop            = resp_ready_and_i[r_head];
                end
            end
            if (m_axil_bvalid) begin
                if (wr_empty) begin
                    b_sink        = 1'b1;
                    m_axil_bready = 1'b1;
                end else if (!r_owns_bus) begin
                    resp_v_o[b_head] = 1'b1;
                    resp_w_o         = 1'b1;
                    resp_err_o       = (m_axil_bresp != 2'b00);
                    m_axil_bready    = resp_ready_and_i[b_head];
                    b_pop            = resp_ready_and_i[b_head];
                end
            end
        end
    end

    always_comb begin
        count_n = count_r;
        if (issue_rd || issue_wr) count_n = count_n + cnt_w'(1);
        if (r_pop) count_n = count_n - cnt_w'(1);
        if (b_pop) count_n = count_n - cnt_w'(1);
    end

    always_ff @(posedge m_axil_aclk or negedge reset) begin
        if (!reset) begin
            state_r     <= e_idle;
            grant_r     <= '0;
            rr_ptr_r    <= '0;
            count_r     <= '0;
            aw_done_r   <= 1'b0;
            w_done_r    <= 1'b0;
            proto_err_r <= 1'b0;
        end else begin
            state_r     <= state_n;
            grant_r     <= grant_n;
            rr_ptr_r    <= rr_ptr_n;
            count_r     <= count_n;
            aw_done_r   <= aw_done_n;
            w_done_r    <= w_done_n;
            proto_err_r <= proto_err_r | r_sink | b_sink;
        end
    end

    assign proto_err_o = proto_err_r;

    bp_axil_id_fifo #(.depth_p(max_outstanding_p), .width_p(idx_w)) rd_fifo (
        .m_axil_aclk (m_axil_aclk),
        .reset       (reset),
        .push        (issue_rd),
        .push_id     (grant_r),
        .pop         (r_pop),
        .head_id     (r_head),
        .empty       (rd_empty)
    );

    bp_axil_id_fifo #(.depth_p(max_outstanding_p), .width_p(idx_w)) wr_fifo (
        .m_axil_aclk (m_axil_aclk),
        .reset       (reset),
        .push        (issue_wr),
        .push_id     (grant_r),
        .pop         (b_pop),
        .head_id     (b_head),
        .empty       (wr_empty)
    );
endmodule

// File: tb/tb_bp_axil_master_arbiter.sv
// Directed scenarios plus a randomized run checked against a transaction-level
// model of the arbiter (request ownership decoded from address/data, per-channel order queues).

module tb_bp_axil_master_arbiter;
    localparam int N  = 2;
    localparam int AW = 64;
    localparam int DW = 32;
    localparam int MO = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    req_v = '0, req_w = '0, req_ready, resp_v, resp_ready = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_data = '0;
    logic            resp_w, resp_err, proto_err;
    logic [DW-1:0]   resp_data;
    logic [AW-1:0]   awaddr, araddr;
    logic            awvalid, awready = 1'b0, wvalid, wready = 1'b0, bvalid = 1'b0, bready;
    logic            arvalid, arready = 1'b0, rvalid = 1'b0, rready;
    logic [2:0]      awprot, arprot;
    logic [DW-1:0]   wdata, rdata = '0;
    logic [DW/8-1:0] wstrb;
    logic [1:0]      bresp = 2'b00, rresp = 2'b00;

    bp_axil_master_arbiter #(.num_req_p(N), .addr_width_p(AW), .data_width_p(DW),
                             .max_outstanding_p(MO)) dut (
        .m_axil_aclk(clk), .reset(reset),
        .req_v_i(req_v), .req_w_i(req_w), .req_addr_i(req_addr), .req_data_i(req_data),
        .req_ready_and_o(req_ready),
        .resp_v_o(resp_v), .resp_w_o(resp_w), .resp_data_o(resp_data), .resp_err_o(resp_err),
        .resp_ready_and_i(resp_ready),
        .m_axil_awaddr(awaddr), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
        .m_axil_awprot(awprot), .m_axil_wdata(wdata), .m_axil_wstrb(wstrb),
        .m_axil_wvalid(wvalid), .m_axil_wready(wready), .m_axil_bvalid(bvalid),
        .m_axil_bready(bready), .m_axil_bresp(bresp), .m_axil_araddr(araddr),
        .m_axil_arvalid(arvalid), .m_axil_arready(arready), .m_axil_arprot(arprot),
        .m_axil_rdata(rdata), .m_axil_rvalid(rvalid), .m_axil_rready(rready),
        .m_axil_rresp(rresp), .proto_err_o(proto_err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_issued = 0;
    int seq = 0;

    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
    } rsp_t;

    rsp_t        rq[$];
    rsp_t        wq[$];
    bit          active[N];
    bit          cur_w[N];
    logic [63:0] cur_addr[N];
    logic [31:0] cur_data[N];
    int          waiting[N];
    bit          aw_got[N];
    bit          w_got[N];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic w, input logic [63:0] a, input logic [31:0] d);
        req_v[id]            = 1'b1;
        req_w[id]            = w;
        req_addr[id*AW +: AW] = a;
        req_data[id*DW +: DW] = d;
    endtask

    task automatic issue(input int id, input logic w, input logic [63:0] a, input logic [31:0] d);
        bit seen;
        seen = 1'b0;
        set_req(id, w, a, d);
        arready = 1'b1; awready = 1'b1; wready = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (req_ready[id]) seen = 1'b1;
            cyc();
        end
        chk("issue_done", seen, 1);
        req_v[id] = 1'b0;
        arready = 1'b0; awready = 1'b0; wready = 1'b0;
    endtask

    task automatic run_random(input int ncyc, input bit sat);
        logic [N-1:0] exp_ready, exp_rv;
        bit           r_fire, b_fire;
        int           id;
        rsp_t         h;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            exp_ready = '0;
            if (arvalid && arready) begin
                id = int'(araddr[15:8]) % N;
                chk("ar_is_read", active[id] && !cur_w[id], 1);
                chk("ar_addr", araddr, cur_addr[id]);
                h.id = 8'(id); h.data = $urandom;
                h.resp = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
                rq.push_back(h);
                exp_ready[id] = 1'b1;
            end
            if (awvalid && awready) begin
                id = int'(awaddr[15:8]) % N;
                chk("aw_is_write", active[id] && cur_w[id], 1);
                chk("aw_addr", awaddr, cur_addr[id]);
                aw_got[id] = 1'b1;
            end
            if (wvalid && wready) begin
                id = int'(wdata[7:0]) % N;
                chk("w_data", wdata, cur_data[id]);
                chk("w_strb", wstrb, 4'hf);
                w_got[id] = 1'b1;
            end
            for (int k = 0; k < N; k++) begin
                if (aw_got[k] && w_got[k]) begin
                    aw_got[k] = 1'b0; w_got[k] = 1'b0;
                    exp_ready[k] = 1'b1;
                    h.id = 8'(k); h.data = '0;
                    h.resp = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00;
                    wq.push_back(h);
                end
            end
            chk("req_ready", req_ready, exp_ready);
            for (int k = 0; k < N; k++) begin
                if (exp_ready[k]) begin
                    chk("rr_wait", waiting[k] <= N - 1, 1);
                    waiting[k] = 0;
                    n_issued++;
                end else if (active[k] && exp_ready != '0) begin
                    waiting[k]++;
                end
            end
            chk("credit", (rq.size() + wq.size()) <= MO, 1);

            exp_rv = '0; r_fire = 1'b0; b_fire = 1'b0;
            if (rvalid) begin
                h = rq[0];
                exp_rv[h.id] = 1'b1;
                chk("r_resp_w", resp_w, 0);
                chk("r_data", resp_data, h.data);
                chk("r_err", resp_err, h.resp != 2'b00);
                chk("rready", rready, resp_ready[h.id]);
                chk("bready_blocked", bready, 0);
                r_fire = resp_ready[h.id];
            end else if (bvalid) begin
                h = wq[0];
                exp_rv[h.id] = 1'b1;
                chk("b_resp_w", resp_w, 1);
                chk("b_data", resp_data, 0);
                chk("b_err", resp_err, h.resp != 2'b00);
                chk("bready", bready, resp_ready[h.id]);
                chk("rready_idle", rready, 0);
                b_fire = resp_ready[h.id];
            end
            chk("resp_v", resp_v, exp_rv);

            cyc();
            if (r_fire) h = rq.pop_front();
            if (b_fire) h = wq.pop_front();
            for (int k = 0; k < N; k++) begin
                if (exp_ready[k]) begin
                    active[k] = 1'b0;
                    req_v[k]  = 1'b0;
                end
            end
            if (!rvalid || r_fire) begin
                rvalid = (rq.size() > 0) && ($urandom_range(0, 2) != 0);
                if (rvalid) begin rdata = rq[0].data; rresp = rq[0].resp; end
            end
            if (!bvalid || b_fire) begin
                bvalid = (wq.size() > 0) && ($urandom_range(0, 2) != 0);
                if (bvalid) bresp = wq[0].resp;
            end
            arready = ($urandom_range(0, 3) != 0);
            awready = ($urandom_range(0, 2) != 0);
            wready  = ($urandom_range(0, 2) != 0);
            for (int k = 0; k < N; k++) resp_ready[k] = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < N; k++) begin
                if (!active[k] && (sat || $urandom_range(0, 1) == 1)) begin
                    active[k]   = 1'b1;
                    cur_w[k]    = 1'($urandom_range(0, 1));
                    seq++;
                    cur_addr[k] = {32'($urandom), 16'(seq), 8'(k), 8'h00};
                    cur_data[k] = {24'($urandom), 8'(k)};
                    set_req(k, cur_w[k], cur_addr[k], cur_data[k]);
                end
            end
        end
    endtask

    initial begin
        // Reset state, with a stray rvalid to confirm nothing is accepted in reset.
        repeat (3) cyc();
        rvalid = 1'b1;
        @(negedge clk);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_bready", bready, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_v", resp_v, 0);
        chk("rst_proto_err", proto_err, 0);
        chk("rst_wstrb", wstrb, 4'hf);
        chk("rst_prot", {awprot, arprot}, 0);
        cyc();
        rvalid = 1'b0;
        reset  = 1'b1;
        cyc();

        // Single read.
        set_req(0, 0, 64'h8, 0);
        arready = 1'b1;
        @(negedge clk);
        chk("rd_grant_cycle_arvalid", arvalid, 0);
        cyc();
        @(negedge clk);
        chk("rd_arvalid", arvalid, 1);
        chk("rd_araddr", araddr, 64'h8);
        chk("rd_ready", req_ready, 2'b01);
        cyc();
        req_v[0] = 1'b0; arready = 1'b0;
        rvalid = 1'b1; rdata = 32'h2; rresp = 2'b00; resp_ready = 2'b01;
        @(negedge clk);
        chk("rd_arvalid_after", arvalid, 0);
        chk("rd_resp_v", resp_v, 2'b01);
        chk("rd_resp_data", resp_data, 32'h2);
        chk("rd_resp_w", resp_w, 0);
        chk("rd_rready", rready, 1);
        cyc();
        rvalid = 1'b0; resp_ready = '0;

        // Write with W accepted first and AW held off three cycles.
        set_req(1, 1, 64'h4, 32'h5);
        awready = 1'b0; wready = 1'b1;
        cyc();
        @(negedge clk);
        chk("wr_wvalid", wvalid, 1);
        chk("wr_wdata", wdata, 32'h5);
        chk("wr_awvalid", awvalid, 1);
        chk("wr_ready_early", req_ready, 0);
        for (int i = 0; i < 2; i++) begin
            cyc();
            @(negedge clk);
            chk("wr_wvalid_done", wvalid, 0);
            chk("wr_ready_wait", req_ready, 0);
        end
        cyc();
        awready = 1'b1;
        @(negedge clk);
        chk("wr_awaddr", awaddr, 64'h4);
        chk("wr_ready", req_ready, 2'b10);
        cyc();
        awready = 1'b0; wready = 1'b0; req_v[1] = 1'b0;
        bvalid = 1'b1; bresp = 2'b00; resp_ready = 2'b10;
        @(negedge clk);
        chk("b_resp_v", resp_v, 2'b10);
        chk("b_resp_w", resp_w, 1);
        chk("b_resp_data", resp_data, 0);
        chk("b_bready", bready, 1);
        cyc();
        bvalid = 1'b0; resp_ready = '0;

        // R and B for the same requester in the same cycle.
        issue(0, 0, 64'h10, 0);
        issue(0, 1, 64'h14, 32'h99);
        rvalid = 1'b1; rdata = 32'hAA; rresp = 2'b00;
        bvalid = 1'b1; bresp = 2'b00; resp_ready = 2'b01;
        @(negedge clk);
        chk("rb_first_v", resp_v, 2'b01);
        chk("rb_first_w", resp_w, 0);
        chk("rb_first_data", resp_data, 32'hAA);
        chk("rb_rready", rready, 1);
        chk("rb_bready_held", bready, 0);
        cyc();
        rvalid = 1'b0;
        @(negedge clk);
        chk("rb_second_v", resp_v, 2'b01);
        chk("rb_second_w", resp_w, 1);
        chk("rb_bready", bready, 1);
        cyc();
        bvalid = 1'b0; resp_ready = '0;

        // Credit limit with R held off.
        begin
            int n_ar;
            n_ar = 0;
            set_req(0, 0, 64'h100, 0);
            arready = 1'b1;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                if (arvalid && arready) n_ar++;
                cyc();
            end
            chk("credit_ar_count", n_ar, MO);
            @(negedge clk);
            chk("credit_stall", arvalid, 0);
            cyc();
            rvalid = 1'b1; rdata = 32'h33; resp_ready = 2'b01;
            @(negedge clk);
            chk("credit_r_accept", rready, 1);
            cyc();
            rvalid = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (arvalid && arready) n_ar++;
                cyc();
            end
            chk("credit_ninth", n_ar, MO + 1);
            req_v[0] = 1'b0; arready = 1'b0;
            rvalid = 1'b1;
            for (int i = 0; i < MO; i++) begin
                @(negedge clk);
                chk("drain_resp_v", resp_v, 2'b01);
                cyc();
            end
            rvalid = 1'b0; resp_ready = '0;
            @(negedge clk);
            chk("drain_proto_err", proto_err, 0);
            cyc();
        end

        // Reset mid-write (AW done, W pending), then a spurious R.
        set_req(1, 1, 64'h20, 32'h7);
        awready = 1'b1; wready = 1'b0;
        cyc();
        cyc();
        awready = 1'b0;
        @(negedge clk);
        chk("mid_awvalid", awvalid, 0);
        chk("mid_wvalid", wvalid, 1);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_valids", {arvalid, awvalid, wvalid}, 0);
        req_v = '0;
        cyc();
        reset = 1'b1;
        rvalid = 1'b1; rdata = '0; resp_ready = '0;
        @(negedge clk);
        chk("spur_rready", rready, 1);
        chk("spur_resp_v", resp_v, 0);
        cyc();
        rvalid = 1'b0;
        @(negedge clk);
        chk("spur_proto_err", proto_err, 1);
        cyc();
        issue(0, 0, 64'h40, 0);

        // Randomized traffic from a clean reset.
        reset = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
        @(negedge clk);
        chk("rand_start_proto_err", proto_err, 0);
        cyc();
        run_random(1500, 1'b0);
        run_random(600, 1'b1);
        chk("rand_progress", n_issued > 200, 1);
        chk("rand_proto_err", proto_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
